// File: rtl/sd_spi_slave.sv
// SPI mode-0 card-side responder: synchronises the master's pins, deserialises bytes,
// assembles 6-byte SD command frames and serialises queued response bytes.
module sd_spi_slave #(
  parameter int unsigned QDEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ck,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  input  logic        resp_wr,
  input  logic [7:0]  resp_d,
  output logic        resp_full
);

  localparam int unsigned AW = $clog2(QDEPTH);

  typedef enum logic [2:0] {StIdle, StColl1, StColl2, StColl3, StColl4, StColl5} fsm_e;

  logic ck_s1, ck_s2, ck_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2, mosi_s3;

  logic [2:0]    bit_cnt_q;
  logic [6:0]    rx_sr_q;
  logic [7:0]    tx_sr_q;
  logic          reload_q;
  logic [37:0]   frame_sr_q;
  fsm_e          state_q, state_d;
  logic          store_en, cmd_load;

  logic [7:0]    mem [QDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic       selected, ck_rise, ck_fall, cs_fall, byte_done, load, pop, push, q_empty;
  logic [7:0] rx_byte, tx_next;

  always_comb begin
    selected  = ~cs_s2;
    ck_rise   = selected & ck_s2 & ~ck_s3;
    ck_fall   = selected & ~ck_s2 & ck_s3;
    cs_fall   = ~cs_s2 & cs_s3;
    byte_done = ck_rise & (bit_cnt_q == 3'd7) & ~cs_fall;
    rx_byte   = {rx_sr_q, mosi_s3};
    load      = cs_fall | byte_done;
    q_empty   = (count_q == '0);
    resp_full = (count_q == (AW+1)'(QDEPTH));
    // A load sees the queue state before this cycle's push.
    pop       = load & ~q_empty;
    push      = resp_wr & (~resp_full | pop);
    tx_next   = q_empty ? 8'hFF : mem[rd_ptr_q];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {ck_s1, ck_s2, ck_s3}       <= 3'b000;
      {cs_s1, cs_s2, cs_s3}       <= 3'b111;
      {mosi_s1, mosi_s2, mosi_s3} <= 3'b111;
    end else begin
      {ck_s1, ck_s2, ck_s3}       <= {ck, ck_s1, ck_s2};
      {cs_s1, cs_s2, cs_s3}       <= {cs, cs_s1, cs_s2};
      {mosi_s1, mosi_s2, mosi_s3} <= {mosi, mosi_s1, mosi_s2};
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= resp_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= 8'hFF;
      reload_q  <= 1'b0;
      miso      <= 1'b1;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!selected) begin
        bit_cnt_q <= '0;
        reload_q  <= 1'b0;
        miso      <= 1'b1;
      end else if (cs_fall) begin
        bit_cnt_q <= '0;
        tx_sr_q   <= tx_next;
        miso      <= tx_next[7];
        reload_q  <= 1'b0;
      end else begin
        if (ck_rise) begin
          rx_sr_q   <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (byte_done) begin
            rx_data  <= rx_byte;
            rx_valid <= 1'b1;
            tx_sr_q  <= tx_next;
            reload_q <= 1'b1;
          end
        end
        if (ck_fall) begin
          // First fall after a reload presents the new MSB instead of shifting.
          if (reload_q) begin
            miso     <= tx_sr_q[7];
            reload_q <= 1'b0;
          end else begin
            tx_sr_q <= {tx_sr_q[6:0], 1'b1};
            miso    <= tx_sr_q[6];
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    store_en = 1'b0;
    cmd_load = 1'b0;
    if (!selected) begin
      state_d = StIdle;
    end else if (byte_done) begin
      case (state_q)
        StIdle: begin
          if (rx_byte[7:6] == 2'b01) begin
            state_d  = StColl1;
            store_en = 1'b1;
          end
        end
        StColl1: begin state_d = StColl2; store_en = 1'b1; end
        StColl2: begin state_d = StColl3; store_en = 1'b1; end
        StColl3: begin state_d = StColl4; store_en = 1'b1; end
        StColl4: begin state_d = StColl5; store_en = 1'b1; end
        StColl5: begin state_d = StIdle;  cmd_load = 1'b1; end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      frame_sr_q <= '0;
      cmd_valid  <= 1'b0;
      cmd_index  <= '0;
      cmd_arg    <= '0;
      cmd_crc    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_valid <= cmd_load;
      // Holds byte0[5:0] followed by bytes 1-4 once five bytes are stored.
      if (store_en) frame_sr_q <= {frame_sr_q[29:0], rx_byte};
      if (cmd_load) begin
        cmd_index <= frame_sr_q[37:32];
        cmd_arg   <= frame_sr_q[31:0];
        cmd_crc   <= rx_byte[7:1];
      end
    end
  end

endmodule

// File: doc/sd_spi_slave.md
# sd_spi_slave

SPI-mode-0 responder: the card end of the uSD link that the Spectrum's `E7h`/`EBh` port master drives. It lets a bench, or an on-chip SD-card emulator, sit on the master's ck/cs/mosi/miso pins. Its functions:
- samples the SPI pins into the system clock domain;
- deserialises bytes and assembles 6-byte SD command frames;
- serialises response bytes from a small queue loaded by the emulator logic.

## Interface
Parameters:
- `QDEPTH`, 4 — response queue depth in bytes; power of two, ≥2.

Ports:
- `clock`  in  1  system clock. All logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ck`  in  1  SPI clock from the master, asynchronous to `clock`.
- `cs`  in  1  chip select from the master, active low, asynchronous.
- `mosi`  in  1  serial data from the master, asynchronous.
- `miso`  out  1  serial data to the master.
- `rx_valid`  out  1  one-cycle pulse: a byte has been received.
- `rx_data`  out  8  last received byte. Holds its value between pulses.
- `cmd_valid`  out  1  one-cycle pulse: a complete command frame has been received.
- `cmd_index`  out  6  command index, taken from frame byte 0 bits [5:0].
- `cmd_arg`  out  32  argument, taken from frame bytes 1–4, MSB first.
- `cmd_crc`  out  7  CRC, taken from frame byte 5 bits [7:1].
- `resp_wr`  in  1  write strobe that pushes `resp_d` into the queue.
- `resp_d`  in  8  response byte.
- `resp_full`  out  1  queue full.

## Operation
Input synchronisation:
- `ck`, `cs` and `mosi` each pass through a 2-FF synchroniser.
- A third register on each supports edge detection.
- Events are `ck` rise, `ck` fall and `cs` fall, each computed on the synchronised signals.

Selection:
- While synchronised `cs` is high, the block is deselected.
- Deselected: bit counter = 0, frame assembler idle, `miso` = 1.
- A `cs` fall loads the transmit shift register: queue head if the queue is non-empty (pop), else `FFh`.
- On that same `cs` fall, `miso` is driven with the loaded byte's MSB.

Byte engine (mode 0, MSB first):
- On `ck` rise, shift `mosi` into the rx shift register and increment the 3-bit counter.
- On `ck` fall, shift the tx register and drive the next bit onto `miso`.
- On the 8th `ck` rise (counter wraps 7→0):
  - `rx_data` ← assembled byte and `rx_valid` pulses;
  - the next tx byte is loaded: queue head (pop) if non-empty, else `FFh`.
- On the `ck` fall that follows the 8th rise, `miso` = MSB of the new byte, not a shift.
- `ck` edges while deselected are ignored.

Frame assembler:
- States are IDLE and COLLECT(n), with n = 1..5.
- IDLE: a received byte with bits [7:6] = `01b` is stored as byte 0, then go to COLLECT(1). Any other byte is ignored.
- COLLECT(n): store the byte as byte n. When n = 5, update `cmd_*` and pulse `cmd_valid`, then return to IDLE.
- A `cs` rise in any state returns to IDLE and discards the partial frame.
- `cmd_*` outputs change only on `cmd_valid`.

Response queue:
- FIFO with `QDEPTH` entries.
- `resp_full` is high when the count = `QDEPTH`.
- `resp_wr` while full and with no simultaneous pop: byte dropped, no state change.
- `resp_wr` in the same cycle as a pop: both take effect and the count is unchanged, including when full.
- Push into an empty queue in the same cycle as a load: the load sees the queue as empty and sends `FFh`; the byte stays queued.
- The queue is not cleared by `cs`. Only `reset` clears it.

Reset values (asynchronous):
- `miso` = 1; `rx_valid` = 0; `rx_data` = 00h.
- `cmd_valid` = 0; `cmd_index` = 0; `cmd_arg` = 0; `cmd_crc` = 0.
- `resp_full` = 0.
- Queue empty, counter = 0, FSM = IDLE, synchroniser registers reset to idle pin levels: `ck` = 0, `cs` = 1, `mosi` = 1.

Reset mid-byte: all of the above apply immediately. After reset is released, the master must deassert `cs` before the next transfer.

## Timing
- Pin-to-event latency: 3 `clock` cycles (2 synchroniser stages plus edge register).
- `rx_valid` is asserted on the cycle after the 8th `ck` rise is detected, i.e. 4 clocks after the pin edge.
- `cmd_valid` is asserted in the same cycle as the `rx_valid` for frame byte 5.
- `miso` settles 4 clocks after a `ck` fall or `cs` fall at the pin.
- Requirement on the master: `ck` high and low phases are each ≥ 4 `clock` periods, and `ck` stays low ≥ 4 clocks after `cs` falls. In practice this means SPI clock ≤ `clock`/8.
- Each pop occurs on the cycle of the load.
- A queue push is visible to a load in the following cycle.

## Test plan
- Reset, then hold `cs` high and toggle `ck` → `miso` = 1, no `rx_valid`, `resp_full` = 0.
- `cs` low, master sends `A5h` with queue empty → `rx_valid` once with `rx_data` = A5h; master samples `FFh`.
- Push `12h`, `34h`, then master sends `40h 00h 00h 00h 00h 95h` → `cmd_valid` after the 6th byte with `cmd_index` = 0, `cmd_arg` = 0, `cmd_crc` = 4Ah. Master samples `12h`, `34h`, then `FFh`×4.
- Send `FFh FFh 48h 00h 00h 01h AAh 87h` → bytes are ignored until `48h`; then `cmd_index` = 8, `cmd_arg` = 000001AAh, `cmd_crc` = 43h.
- Send `51h 00h 00h`, raise `cs`, lower `cs`, send `41h 00h 00h 00h 00h F9h` → exactly one `cmd_valid`, with `cmd_index` = 1.
- Push 5 bytes with `QDEPTH` = 4 → `resp_full` goes high after the 4th push and the 5th push is dropped. The master then reads bytes 1–4 in order, followed by `FFh`. Finally, assert `reset` mid-byte → all outputs at their reset values within 1 cycle.
